// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and binary pointers.
// Each pointer carries one wrap bit above the memory index, so full and empty
// can be told apart. Status flags are decoded combinationally from the
// registered pointers, so they change in the same cycle as the pointers.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter int unsigned MARGIN     = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned ADDR_WIDTH = PTR_WIDTH - 1;
  localparam int unsigned MARGIN_MOD = MARGIN % FIFO_DEPTH;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  wr_accept;
  logic                  rd_accept;

  // Requests are qualified by the flags as they stand before the edge.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  // Pointers, registered read data and the rejection pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_accept) begin
        wptr <= wptr + PTR_WIDTH'(1);
      end
      if (rd_accept) begin
        rdata <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr  <= rptr + PTR_WIDTH'(1);
      end
    end
  end

  // Occupancy and full/empty decode; the wrap bit separates full from empty.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_WIDTH-1] != rptr[PTR_WIDTH-1]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // Almost flags collapse onto full/empty when the margin is a multiple of the depth.
  if (MARGIN_MOD == 0) begin : g_margin_zero
    assign almostfull  = full;
    assign almostempty = empty;
  end else begin : g_margin_nonzero
    assign almostfull  = (count == PTR_WIDTH'(FIFO_DEPTH - MARGIN_MOD));
    assign almostempty = (count == PTR_WIDTH'(MARGIN_MOD));
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: checks sync_fifo (depth 8) against a queue-based reference
// model. A second instance with MARGIN=8 shares the stimulus so that its
// almost flags can be checked against full/empty.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 4;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;

  logic [DW-1:0] rdata, rdata_m0;
  logic [PW-1:0] wptr, rptr, count, wptr_m0, rptr_m0, count_m0;
  logic full, empty, almostfull, almostempty, overflow, underflow;
  logic full_m0, empty_m0, af_m0, ae_m0, ovf_m0, unf_m0;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW), .MARGIN(2)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .wptr(wptr), .rptr(rptr), .count(count),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW), .MARGIN(8)) dut_m0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata_m0), .wptr(wptr_m0), .rptr(rptr_m0), .count(count_m0),
    .full(full_m0), .empty(empty_m0), .almostfull(af_m0), .almostempty(ae_m0),
    .overflow(ovf_m0), .underflow(unf_m0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the FIFO contents as a queue plus totals.
  logic [DW-1:0] model_q [$];
  int            wr_total;
  int            rd_total;
  logic [DW-1:0] exp_rdata;
  logic          exp_ovf;
  logic          exp_unf;

  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    wr_total  = 0;
    rd_total  = 0;
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // Compare every observable output of both instances against the model.
  task automatic check_all();
    int n;
    n = model_q.size();
    check("rdata",       32'(rdata),       32'(exp_rdata));
    check("wptr",        32'(wptr),        32'(wr_total % 16));
    check("rptr",        32'(rptr),        32'(rd_total % 16));
    check("count",       32'(count),       32'(n));
    check("full",        32'(full),        32'(n == DEPTH));
    check("empty",       32'(empty),       32'(n == 0));
    check("almostfull",  32'(almostfull),  32'(n == DEPTH - 2));
    check("almostempty", 32'(almostempty), 32'(n == 2));
    check("overflow",    32'(overflow),    32'(exp_ovf));
    check("underflow",   32'(underflow),   32'(exp_unf));
    check("m0_rdata",    32'(rdata_m0),    32'(exp_rdata));
    check("m0_af",       32'(af_m0),       32'(n == DEPTH));
    check("m0_ae",       32'(ae_m0),       32'(n == 0));
    check("m0_count",    32'(count_m0),    32'(n));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    int n;
    @(negedge clk);
    wr_en = w;
    wdata = d;
    rd_en = r;
    @(posedge clk);
    n       = model_q.size();
    exp_ovf = w && (n == DEPTH);
    exp_unf = r && (n == 0);
    if (r && n != 0) begin
      exp_rdata = model_q.pop_front();
      rd_total++;
    end
    if (w && n != DEPTH) begin
      model_q.push_back(d);
      wr_total++;
    end
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    logic [DW-1:0] pat;
    tests_run    = 0;
    tests_failed = 0;
    rstn  = 1'b0;
    wr_en = 1'b0;
    wdata = '0;
    rd_en = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_all();

    // Fill with 0x10..0x17, then one rejected write.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Steady-state streaming at occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);

    // Top up to full, then write+read together while full.
    while (model_q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'h5A, 1'b1);

    // Drain to empty, then write+read together while empty.
    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hC3, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a burst at occupancy 5.
    while (model_q.size() < 5) cycle(1'b1, 8'($urandom), 1'b0);
    @(negedge clk);
    wr_en = 1'b1;
    wdata = 8'h77;
    rd_en = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rstn  = 1'b1;
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      p   = ((i / 50) % 2 == 0) ? 70 : 30;
      pat = 8'($urandom);
      cycle(1'($urandom_range(0, 99) < p), pat, 1'($urandom_range(0, 99) >= p));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised synchronous FIFO with registered read data, Gray-free binary pointers carrying one wrap bit, and full/empty/almost-full/almost-empty status. It is the DUT monitored by the FIFO assertion checker: its `wptr`, `rptr` and four status flags are exported as ports so the checker binds directly to them. It sits between the stimulus driver (write side) and the scoreboard/monitor (read side) in the verification environment.

## Interface
- `DATA_WIDTH`, default 8: width of one stored word.
- `FIFO_DEPTH`, default 16: number of entries; must be a power of two ≥ 2.
- `PTR_WIDTH`, default $clog2(FIFO_DEPTH)+1: pointer width; the MSB is the wrap bit, the low `PTR_WIDTH-1` bits index memory.
- `MARGIN`, default 2: almost-flag distance; only `MARGIN mod FIFO_DEPTH` is used.

- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write request.
- `wdata` in DATA_WIDTH: write data.
- `rd_en` in 1: read request.
- `rdata` out DATA_WIDTH: registered read data.
- `wptr` out PTR_WIDTH: write pointer (registered).
- `rptr` out PTR_WIDTH: read pointer (registered).
- `count` out PTR_WIDTH: occupancy, 0..FIFO_DEPTH.
- `full` out 1, `empty` out 1, `almostfull` out 1, `almostempty` out 1: status.
- `overflow` out 1: one-cycle pulse, write rejected.
- `underflow` out 1: one-cycle pulse, read rejected.

## Operation
- Reset (`rstn`=0, takes effect immediately): `wptr`=`rptr`=0, `rdata`=0, `overflow`=`underflow`=0; hence `count`=0, `empty`=1, `full`=0, `almostfull`=0, `almostempty`=1 if `MARGIN mod FIFO_DEPTH`==0 else 0. Memory contents are not reset.
- Accepted write: `wr_en && !full` at edge → `mem[wptr[PTR_WIDTH-2:0]] <= wdata`, `wptr <= wptr+1` (modulo 2^PTR_WIDTH).
- Accepted read: `rd_en && !empty` at edge → `rdata <= mem[rptr[PTR_WIDTH-2:0]]`, `rptr <= rptr+1`. No accepted read → `rdata` holds.
- Rejected write (`wr_en && full`): no memory/pointer change; `overflow`=1 for the next cycle. Rejected read (`rd_en && empty`): no change; `underflow`=1 for the next cycle.
- Flags are combinational decodes of the registered pointers (valid in the same cycle the pointers change):
  - `count` = `wptr - rptr` (PTR_WIDTH-bit modular subtraction).
  - `empty` = (`wptr == rptr`).
  - `full` = MSBs differ and low bits equal.
  - Let M = `MARGIN mod FIFO_DEPTH`. If M≠0: `almostfull` = (`count` == FIFO_DEPTH−M); `almostempty` = (`count` == M). If M=0: `almostfull` = `full`, `almostempty` = `empty`.
- Simultaneous write+read: each is qualified by flags sampled before the edge. When full: read accepted, write rejected (overflow pulse). When empty: write accepted, read rejected (underflow pulse); no write-to-read bypass. Otherwise both accepted, `count` unchanged.

## Timing
- Write-to-read: a word written at edge N is readable at edge N+1 earliest; appears on `rdata` after that read edge (1-cycle read latency).
- Pointer/flag update: 1 edge after the accepting request; flags settle combinationally with pointers.
- Wrap: low bits wrap at FIFO_DEPTH, MSB toggles; full pointer wrap at 2·FIFO_DEPTH is seamless.
- Reset mid-operation: all outputs go to reset values asynchronously regardless of in-flight requests; first accepted operation is at the first edge with `rstn`=1.

## Test plan
- DEPTH=8, MARGIN=2: hold reset, release → `wptr`=`rptr`=0, `empty`=1, `full`=0, `almostfull`=0, `almostempty`=0, `rdata`=0.
- Write 8 words 0x10..0x17 back-to-back → `count` steps 1..8, `almostempty`=1 only at count 2, `almostfull`=1 only at count 6, `full`=1 after 8th, `wptr`=8 (MSB set); 9th write → `overflow` pulse, `wptr` stays 8.
- From full, read 8 → `rdata` 0x10..0x17 each one cycle after its read edge, `empty`=1 at end, extra read → `underflow` pulse, `rptr` stays 8.
- Run 40 interleaved write/read pairs at count 3 → `count` stays 3, pointers wrap past 15→0, data order preserved.
- Full + simultaneous `wr_en`/`rd_en` → read accepted, write rejected, `count`=7; empty + both → write accepted, `rdata` unchanged, `count`=1.
- Assert `rstn`=0 mid-burst at count 5 → outputs reset immediately; after release, write 0xAA/read returns 0xAA. MARGIN=8 run: `almostempty`==`empty`, `almostfull`==`full` throughout.
